// File: rtl/cover_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cover_pkg
// Description : Shared constants and helpers for the toggle coverage tracker.
//               Defines the width of the global cover-point index and the
//               mapping from (bit, direction) to a local point id.
// Revision    : 1.0 - initial release
// ============================================================================
package cover_pkg;

    localparam int COVER_IDX_W = 64;

    // Local point id: even ids are rising toggles, odd ids are falling toggles.
    function automatic int unsigned point_id(input int unsigned b, input logic fall);
        return 2 * b + {31'd0, fall};
    endfunction

endpackage : cover_pkg
`default_nettype wire

// File: rtl/cover_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : cover_prio_enc
// Description : Combinational lowest-set-bit priority encoder.
//   i_req  in  N           request vector
//   o_idx  out $clog2(N)   index of the lowest set bit (0 when none set)
//   o_any  out 1           at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module cover_prio_enc #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_idx = IW'(k);
                o_any = 1'b1;
            end
        end
    end

endmodule : cover_prio_enc
`default_nettype wire

// File: rtl/cover_toggle_tracker.sv
`default_nettype none
// ============================================================================
// Module      : cover_toggle_tracker
// Description : Multi-bit toggle cover point. Samples a WIDTH-bit signal on
//               valid, detects per-bit rise/fall toggles, de-duplicates them
//               in a hit bitmap and reports each newly covered point once
//               over a valid/ready port.
//   clock        in   1        clock, all state on posedge
//   reset        in   1        synchronous active-high reset
//   valid        in   1        sample qualifier for signal
//   signal       in   WIDTH    monitored value
//   clear_hits   in   1        forget hit bitmap; pending reports are kept
//   cover_valid  out  1        report holds a new point
//   cover_ready  in   1        collector accepts the report
//   cover_index  out  64       COVER_INDEX + 2*bit + (falling ? 1 : 0)
//   hit_count    out  CNT_W    distinct points hit since reset/clear
// Revision    : 1.0 - initial release
// ============================================================================
module cover_toggle_tracker
    import cover_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 8065
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           valid,
    input  logic [WIDTH-1:0]               signal,
    input  logic                           clear_hits,
    output logic                           cover_valid,
    input  logic                           cover_ready,
    output logic [COVER_IDX_W-1:0]         cover_index,
    output logic [$clog2(2*WIDTH+1)-1:0]   hit_count
);

    localparam int NPTS  = 2 * WIDTH;
    localparam int CNT_W = $clog2(NPTS + 1);
    localparam int IDX_W = $clog2(NPTS);

    generate
        if (COVER_INDEX + 2 * WIDTH > COVER_TOTAL) begin : g_range_check
            $error("cover_toggle_tracker: COVER_INDEX + 2*WIDTH exceeds COVER_TOTAL");
        end
    endgenerate

    logic [WIDTH-1:0]        r_prev;
    logic                    r_base_ok;
    logic [NPTS-1:0]         r_hit;
    logic [NPTS-1:0]         r_pending;
    logic                    r_cover_valid;
    logic [COVER_IDX_W-1:0]  r_cover_index;
    logic [CNT_W-1:0]        r_hit_count;

    logic                    w_sample;
    logic [NPTS-1:0]         w_toggle;
    logic [NPTS-1:0]         w_hit_base;
    logic [NPTS-1:0]         w_new;
    logic [NPTS-1:0]         w_take_mask;
    logic [CNT_W-1:0]        w_cnt_base;
    logic [CNT_W-1:0]        w_new_cnt;
    logic                    w_load;
    logic                    w_any;
    logic [IDX_W-1:0]        w_pidx;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NPTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NPTS; k++) begin
            c = c + CNT_W'(v[k]);
        end
        return c;
    endfunction

    // Toggles only count once a baseline sample exists.
    assign w_sample = valid && r_base_ok;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign w_toggle[point_id(i, 1'b0)] = w_sample & ~r_prev[i] &  signal[i];
            assign w_toggle[point_id(i, 1'b1)] = w_sample &  r_prev[i] & ~signal[i];
        end
    endgenerate

    // A clear in the same cycle as a toggle judges the toggle against the
    // already-cleared bitmap, so it is counted as new.
    assign w_hit_base = clear_hits ? '0 : r_hit;
    assign w_cnt_base = clear_hits ? '0 : r_hit_count;
    assign w_new      = w_toggle & ~w_hit_base;
    assign w_new_cnt  = popcnt(w_new);

    cover_prio_enc #(
        .N (NPTS)
    ) u_prio_enc (
        .i_req (r_pending),
        .o_idx (w_pidx),
        .o_any (w_any)
    );

    // The report register refills when empty or when its content is accepted.
    assign w_load      = !r_cover_valid || cover_ready;
    assign w_take_mask = (w_load && w_any) ? (NPTS'(1) << w_pidx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev        <= '0;
            r_base_ok     <= 1'b0;
            r_hit         <= '0;
            r_pending     <= '0;
            r_cover_valid <= 1'b0;
            r_cover_index <= '0;
            r_hit_count   <= '0;
        end else begin
            if (valid) begin
                r_prev    <= signal;
                r_base_ok <= 1'b1;
            end
            r_hit       <= w_hit_base | w_new;
            r_hit_count <= w_cnt_base + w_new_cnt;
            r_pending   <= (r_pending & ~w_take_mask) | w_new;
            if (w_load) begin
                r_cover_valid <= w_any;
                if (w_any) begin
                    r_cover_index <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(w_pidx);
                end
            end
        end
    end

    assign cover_valid = r_cover_valid;
    assign cover_index = r_cover_index;
    assign hit_count   = r_hit_count;

endmodule : cover_toggle_tracker
`default_nettype wire

// File: tb/tb_cover_toggle_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cover_toggle_tracker
// Description : Scoreboard bench for cover_toggle_tracker (WIDTH=4,
//               COVER_INDEX=100). Stimulus pushes expected report indices;
//               a monitor pops and compares on every accepted report.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cover_toggle_tracker;

    localparam int W    = 4;
    localparam int BASE = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [W-1:0] signal = '0;
    logic        clear_hits = 1'b0;
    logic        cover_valid;
    logic        cover_ready = 1'b1;
    logic [63:0] cover_index;
    logic [3:0]  hit_count;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    cover_toggle_tracker #(
        .WIDTH       (W),
        .COVER_INDEX (BASE),
        .COVER_TOTAL (8065)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .signal      (signal),
        .clear_hits  (clear_hits),
        .cover_valid (cover_valid),
        .cover_ready (cover_ready),
        .cover_index (cover_index),
        .hit_count   (hit_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops on each accepted report and checks stability while stalled.
    logic        stall_prev = 1'b0;
    logic [63:0] held_idx   = '0;
    always @(negedge clock) begin
        if (stall_prev) begin
            chk("stall_valid", {63'd0, cover_valid}, 64'd1);
            chk("stall_index", cover_index, held_idx);
        end
        if (!reset && cover_valid && cover_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_report", cover_index, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("report_index", cover_index, exp_q.pop_front());
            end
        end
        stall_prev = cover_valid && !cover_ready && !reset;
        held_idx   = cover_index;
    end

    // Apply one cycle of inputs; they are sampled at the next posedge.
    task automatic drive(input logic v, input logic [W-1:0] s, input logic clr);
        valid      = v;
        signal     = s;
        clear_hits = clr;
        @(posedge clock);
        #1;
        valid      = 1'b0;
        clear_hits = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state ----
        #1;
        do_reset();
        @(negedge clock);
        chk("reset_valid", {63'd0, cover_valid}, 64'd0);
        chk("reset_count", {60'd0, hit_count}, 64'd0);
        @(posedge clock);
        #1;

        // ---- single rise then fall on bit 0 ----
        drive(1'b1, 4'b0000, 1'b0);
        exp_q.push_back(BASE + 0);
        drive(1'b1, 4'b0001, 1'b0);
        idle(3);
        chk("count_after_rise", {60'd0, hit_count}, 64'd1);
        exp_q.push_back(BASE + 1);
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0000, 1'b0);
        idle(4);
        chk("count_no_dup", {60'd0, hit_count}, 64'd2);
        chk("queue_drained_1", 64'(exp_q.size()), 64'd0);

        // ---- all bits rise under back-pressure ----
        do_reset();
        cover_ready = 1'b0;
        drive(1'b1, 4'h0, 1'b0);
        exp_q.push_back(BASE + 0);
        exp_q.push_back(BASE + 2);
        exp_q.push_back(BASE + 4);
        exp_q.push_back(BASE + 6);
        drive(1'b1, 4'hF, 1'b0);
        idle(5);
        @(negedge clock);
        chk("stall_held_valid", {63'd0, cover_valid}, 64'd1);
        chk("stall_held_index", cover_index, 64'(BASE + 0));
        chk("count_all_rise", {60'd0, hit_count}, 64'd4);
        @(posedge clock);
        #1;
        cover_ready = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("b2b_valid", {63'd0, cover_valid}, 64'd1);
        end
        idle(3);
        chk("queue_drained_2", 64'(exp_q.size()), 64'd0);

        // ---- first sample is baseline only; invalid cycles ignored ----
        do_reset();
        drive(1'b1, 4'hF, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        drive(1'b0, 4'h5, 1'b0);
        drive(1'b1, 4'hF, 1'b0);
        idle(3);
        chk("baseline_count", {60'd0, hit_count}, 64'd0);
        chk("baseline_valid", {63'd0, cover_valid}, 64'd0);
        exp_q.push_back(BASE + 3);
        drive(1'b1, 4'hD, 1'b0);
        idle(3);
        chk("fall_bit1_count", {60'd0, hit_count}, 64'd1);

        // ---- clear_hits with simultaneous re-hit of bit 1 rise ----
        exp_q.push_back(BASE + 2);
        drive(1'b1, 4'hF, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        idle(3);
        chk("pre_clear_count", {60'd0, hit_count}, 64'd2);
        exp_q.push_back(BASE + 2);
        drive(1'b1, 4'hF, 1'b1);
        idle(3);
        chk("clear_count", {60'd0, hit_count}, 64'd1);
        chk("queue_drained_3", 64'(exp_q.size()), 64'd0);

        // ---- reset while a report is held and more are pending ----
        do_reset();
        cover_ready = 1'b0;
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b1, 4'hF, 1'b0);
        idle(2);
        @(negedge clock);
        chk("pre_reset_valid", {63'd0, cover_valid}, 64'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cover_ready = 1'b1;
        @(negedge clock);
        chk("midreset_valid", {63'd0, cover_valid}, 64'd0);
        chk("midreset_count", {60'd0, hit_count}, 64'd0);
        idle(6);
        chk("no_stale_valid", {63'd0, cover_valid}, 64'd0);
        chk("queue_final", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cover_toggle_tracker
`default_nettype wire
